// File: rtl/packet_decoder_if.sv
// Byte-stream bus around the packet decoder: upstream frame bytes in,
// payload beats out. The decoder sits on the slave side.
interface packet_decoder_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last
   );
endinterface

// File: rtl/packet_decoder.sv
// Receive-side frame decoder: dest, N, N payload bytes, XOR parity.
// Payload is buffered and replayed downstream only for good frames
// addressed to this node or broadcast; everything else is flagged and dropped.
module packet_decoder #(
   parameter logic [7:0] MY_ADDR    = 8'h05,
   parameter logic [7:0] BCAST_ADDR = 8'hFF,
   parameter int         CNT_W      = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   packet_decoder_if.slave  bus,
   output logic [7:0]       o_pkt_dest,
   output logic [7:0]       o_pkt_len,
   output logic             o_pkt_ok,
   output logic             o_parity_err,
   output logic             o_addr_drop,
   output logic [CNT_W-1:0] o_good_cnt,
   output logic [CNT_W-1:0] o_err_cnt
);

   typedef enum logic [2:0] {
      S_ADDR, S_LEN, S_PAYLOAD, S_PARITY, S_SEND
   } state_t;

   state_t           r_state, w_next;
   logic [7:0]       r_dest, r_len, r_par, r_wptr, r_rptr;
   logic [7:0]       r_buf [256];
   logic [7:0]       r_pkt_dest, r_pkt_len;
   logic             r_pkt_ok, r_parity_err, r_addr_drop;
   logic [CNT_W-1:0] r_good_cnt, r_err_cnt;

   logic       w_in_ready, w_in_fire, w_out_valid, w_out_fire;
   logic       w_par_ok, w_addr_ok;
   logic [7:0] w_last_idx;

   // The last payload index is only meaningful when N != 0; N == 0 never
   // reaches PAYLOAD or SEND, so the wrap to 8'hFF is harmless.
   assign w_last_idx  = r_len - 8'd1;
   assign w_in_ready  = !i_rst && (r_state != S_SEND);
   assign w_in_fire   = bus.in_valid && w_in_ready;
   assign w_out_valid = (r_state == S_SEND);
   assign w_out_fire  = w_out_valid && bus.out_ready;
   assign w_par_ok    = (bus.in_data == r_par);
   assign w_addr_ok   = (r_dest == MY_ADDR) || (r_dest == BCAST_ADDR);

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   // Buffer contents are not reset, so gate the read to keep out_data at 0
   // whenever no beat is being presented.
   assign bus.out_data  = w_out_valid ? r_buf[r_rptr] : 8'h00;
   assign bus.out_last  = w_out_valid && (r_rptr == w_last_idx);

   assign o_pkt_dest   = r_pkt_dest;
   assign o_pkt_len    = r_pkt_len;
   assign o_pkt_ok     = r_pkt_ok;
   assign o_parity_err = r_parity_err;
   assign o_addr_drop  = r_addr_drop;
   assign o_good_cnt   = r_good_cnt;
   assign o_err_cnt    = r_err_cnt;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_ADDR;
      else       r_state <= w_next;
   end

   // Next-state: walk the frame fields, then replay accepted payload.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_ADDR:    if (w_in_fire) w_next = S_LEN;
         S_LEN:     if (w_in_fire) w_next = (bus.in_data == 8'h00) ? S_PARITY : S_PAYLOAD;
         S_PAYLOAD: if (w_in_fire && (r_wptr == w_last_idx)) w_next = S_PARITY;
         S_PARITY:  if (w_in_fire)
                       w_next = (w_par_ok && w_addr_ok && (r_len != 8'h00)) ? S_SEND : S_ADDR;
         S_SEND:    if (w_out_fire && (r_rptr == w_last_idx)) w_next = S_ADDR;
         default:   w_next = S_ADDR;
      endcase
   end

   // Frame fields, running parity, pointers, status pulses and counters.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dest       <= 8'h00;
         r_len        <= 8'h00;
         r_par        <= 8'h00;
         r_wptr       <= 8'h00;
         r_rptr       <= 8'h00;
         r_pkt_dest   <= 8'h00;
         r_pkt_len    <= 8'h00;
         r_pkt_ok     <= 1'b0;
         r_parity_err <= 1'b0;
         r_addr_drop  <= 1'b0;
         r_good_cnt   <= '0;
         r_err_cnt    <= '0;
      end else begin
         r_pkt_ok     <= 1'b0;
         r_parity_err <= 1'b0;
         r_addr_drop  <= 1'b0;
         case (r_state)
            S_ADDR: if (w_in_fire) begin
               r_dest <= bus.in_data;
               r_par  <= bus.in_data;
            end
            S_LEN: if (w_in_fire) begin
               r_len  <= bus.in_data;
               r_par  <= r_par ^ bus.in_data;
               r_wptr <= 8'h00;
            end
            S_PAYLOAD: if (w_in_fire) begin
               r_par  <= r_par ^ bus.in_data;
               r_wptr <= r_wptr + 8'd1;
            end
            S_PARITY: if (w_in_fire) begin
               if (!w_par_ok) begin
                  r_parity_err <= 1'b1;
                  if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
               end else if (!w_addr_ok) begin
                  r_addr_drop <= 1'b1;
               end else begin
                  r_pkt_ok   <= 1'b1;
                  r_pkt_dest <= r_dest;
                  r_pkt_len  <= r_len;
                  r_rptr     <= 8'h00;
                  if (r_good_cnt != '1) r_good_cnt <= r_good_cnt + CNT_W'(1);
               end
            end
            S_SEND: if (w_out_fire) r_rptr <= r_rptr + 8'd1;
            default: ;
         endcase
      end
   end

   // Payload storage; no reset, stale bytes are never read back.
   always_ff @(posedge i_clk) begin
      if (!i_rst && (r_state == S_PAYLOAD) && w_in_fire)
         r_buf[r_wptr] <= bus.in_data;
   end

endmodule

// File: tb/tb_packet_decoder.sv
// Scoreboard bench for packet_decoder: frames are issued byte by byte, a
// frame-level model predicts beats and status events, and a negedge monitor
// compares whatever the decoder presents.
module tb_packet_decoder;
   localparam int CNT_W = 4;
   localparam int SAT   = (1 << CNT_W) - 1;

   typedef logic [7:0] byte_q_t [$];
   typedef struct { logic [7:0] data; logic last; } beat_t;
   typedef struct {
      int kind;               // 0 ok, 1 parity error, 2 address drop
      logic [7:0] dest, len;
      int good, err;
   } evt_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   packet_decoder_if bus();
   logic [7:0]       pkt_dest, pkt_len;
   logic             pkt_ok, parity_err, addr_drop;
   logic [CNT_W-1:0] good_cnt, err_cnt;

   packet_decoder #(.MY_ADDR(8'h05), .BCAST_ADDR(8'hFF), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus),
      .o_pkt_dest(pkt_dest), .o_pkt_len(pkt_len), .o_pkt_ok(pkt_ok),
      .o_parity_err(parity_err), .o_addr_drop(addr_drop),
      .o_good_cnt(good_cnt), .o_err_cnt(err_cnt)
   );

   beat_t beat_q[$];
   evt_t  evt_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int m_good = 0, m_err = 0;
   logic [7:0] m_dest = 8'h00, m_len = 8'h00;
   int rdy_mode = 0;   // 0 always ready, 1 random, 2 pattern 1,0,0,1
   bit gaps = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Downstream ready generator.
   always @(posedge clk) begin
      int pc;
      #1;
      case (rdy_mode)
         0: bus.out_ready = 1'b1;
         1: bus.out_ready = ($urandom_range(0, 2) != 0);
         default: bus.out_ready = ((pc % 4) == 0) || ((pc % 4) == 3);
      endcase
      pc++;
   end

   // Monitor: status pulses against the event queue, beats against the beat queue.
   always @(negedge clk) begin
      int np;
      int kind;
      evt_t e;
      bit have_hold;
      logic [7:0] hold_data;
      logic hold_last;
      if (rst) begin
         have_hold = 1'b0;
      end else begin
         np = int'(pkt_ok) + int'(parity_err) + int'(addr_drop);
         if (np != 0) begin
            check("pulse_onehot", np, 1);
            check("pulse_expected", evt_q.size() != 0, 1);
            if (evt_q.size() != 0) begin
               e = evt_q.pop_front();
               kind = pkt_ok ? 0 : (parity_err ? 1 : 2);
               check("pulse_kind", kind, e.kind);
               check("good_cnt", good_cnt, e.good);
               check("err_cnt", err_cnt, e.err);
               check("pkt_dest", pkt_dest, e.dest);
               check("pkt_len", pkt_len, e.len);
               if (e.kind == 0 && e.len != 8'h00)
                  check("first_beat_latency", bus.out_valid, 1);
            end
         end
         if (have_hold) begin
            check("valid_held", bus.out_valid, 1);
            check("hold_data", bus.out_data, hold_data);
            check("hold_last", bus.out_last, hold_last);
         end
         have_hold = 1'b0;
         if (bus.out_valid) begin
            check("in_ready_low_in_send", bus.in_ready, 0);
            check("beat_expected", beat_q.size() != 0, 1);
            if (beat_q.size() != 0) begin
               check("out_data", bus.out_data, beat_q[0].data);
               check("out_last", bus.out_last, beat_q[0].last);
               if (bus.out_ready) begin
                  void'(beat_q.pop_front());
               end else begin
                  have_hold = 1'b1;
                  hold_data = bus.out_data;
                  hold_last = bus.out_last;
               end
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         waited++;
         if (waited > 3000) begin
            n_fail++;
            $display("FAIL in_ready_timeout: in_ready stuck at 0, required 1");
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $fatal(1, "stalled");
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Frame-level model: parse the byte list, predict outcome, then drive it.
   task automatic issue(input byte_q_t fr);
      logic [7:0] x = 8'h00;
      int n;
      evt_t e;
      for (int i = 0; i < fr.size() - 1; i++) x ^= fr[i];
      n = fr[1];
      if (x != fr[fr.size() - 1]) begin
         m_err = (m_err >= SAT) ? SAT : m_err + 1;
         e.kind = 1;
      end else if (fr[0] == 8'h05 || fr[0] == 8'hFF) begin
         m_good = (m_good >= SAT) ? SAT : m_good + 1;
         m_dest = fr[0];
         m_len  = fr[1];
         e.kind = 0;
         for (int i = 0; i < n; i++) beat_q.push_back('{fr[2 + i], i == n - 1});
      end else begin
         e.kind = 2;
      end
      e.dest = m_dest; e.len = m_len; e.good = m_good; e.err = m_err;
      evt_q.push_back(e);
      foreach (fr[i]) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         send_byte(fr[i]);
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((beat_q.size() != 0 || evt_q.size() != 0) && t < 5000) begin
         @(posedge clk); t++;
      end
      check("drained", beat_q.size() + evt_q.size(), 0);
      @(posedge clk); #1;
   endtask

   function automatic byte_q_t rand_frame(input logic [7:0] dest, input int n, input bit bad);
      byte_q_t q;
      logic [7:0] p, b;
      q.push_back(dest);
      q.push_back(8'(n));
      p = dest ^ 8'(n);
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         q.push_back(b);
         p ^= b;
      end
      if (bad) p ^= 8'(1 << $urandom_range(0, 7));
      q.push_back(p);
      return q;
   endfunction

   initial begin
      byte_q_t fr;
      logic [7:0] d;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_pulses", {pkt_ok, parity_err, addr_drop}, 0);
      check("rst_pkt_dest", pkt_dest, 0);
      check("rst_pkt_len", pkt_len, 0);
      check("rst_cnts", {good_cnt, err_cnt}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", bus.in_ready, 1);
      @(posedge clk); #1;

      issue('{8'h05, 8'h03, 8'h11, 8'h22, 8'h33, 8'h06}); drain();
      issue('{8'h05, 8'h03, 8'h11, 8'h22, 8'h33, 8'h07}); drain();
      issue('{8'h09, 8'h01, 8'hAA, 8'hA2});
      @(negedge clk);
      check("in_ready_after_drop", bus.in_ready, 1);
      drain();
      issue('{8'hFF, 8'h00, 8'hFF}); drain();

      // Backpressure with the next frame queued up behind SEND.
      rdy_mode = 2;
      issue('{8'h05, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
      issue('{8'h05, 8'h01, 8'h77, 8'h73});
      drain();

      // Reset in the middle of a frame.
      rdy_mode = 1;
      send_byte(8'h05); send_byte(8'h03); send_byte(8'h11);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_good = 0; m_err = 0; m_dest = 8'h00; m_len = 8'h00;
      @(negedge clk);
      check("midrst_cnts", {good_cnt, err_cnt}, 0);
      check("midrst_pkt_dest", pkt_dest, 0);
      @(posedge clk); #1;
      issue('{8'h05, 8'h03, 8'h11, 8'h22, 8'h33, 8'h06}); drain();

      // Longest frame.
      issue(rand_frame(8'h05, 255, 1'b0)); drain();

      // Random traffic; also pushes the small counters into saturation.
      gaps = 1'b1;
      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 2))
            0: d = 8'h05;
            1: d = 8'hFF;
            default: d = 8'($urandom);
         endcase
         issue(rand_frame(d, $urandom_range(0, 12), $urandom_range(0, 2) == 0));
      end
      drain();
      @(negedge clk);
      check("final_good_cnt", good_cnt, m_good);
      check("final_err_cnt", err_cnt, m_err);
      check("final_idle", bus.out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
